// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word at a time over req/ack,
// buffers it for decode, follows branch redirects and stops after HALT_OP.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]        HALT_OP  = 6'd63
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   next_pc_q, next_pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic                flush_q, flush_d;
  logic [ADDR_W-1:0]   flush_target;

  // Decode handshake: an instruction moves to decode in any cycle where
  // instr_valid and instr_ready are both high; the buffer is stable until then.
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign op          = instr_q[INSTR_W-1 -: 6];
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign dbg_state_o = state_q;

  // A same-cycle redirect wins over one latched earlier in the request.
  assign flush_target = redirect ? redirect_target : next_pc_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    next_pc_d = next_pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    flush_d   = flush_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        addr_d  = next_pc_q;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (flush_q || redirect) begin
            // Stale data: drop it and re-issue the request at the branch target.
            next_pc_d = flush_target;
            addr_d    = flush_target;
            flush_d   = 1'b0;
          end else begin
            instr_d   = imem_rdata;
            pc_out_d  = addr_q;
            valid_d   = 1'b1;
            next_pc_d = addr_q + ADDR_W'(1);
            req_d     = 1'b0;
            state_d   = S_HOLD;
          end
        end else if (redirect) begin
          next_pc_d = redirect_target;
          flush_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          valid_d   = 1'b0;
          next_pc_d = redirect_target;
          req_d     = 1'b1;
          addr_d    = redirect_target;
          state_d   = S_FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          if (op == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            req_d   = 1'b1;
            addr_d  = next_pc_q;
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        if (redirect) begin
          halted_d  = 1'b0;
          next_pc_d = redirect_target;
          req_d     = 1'b1;
          addr_d    = redirect_target;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      next_pc_q <= RESET_PC;
      instr_q   <= '0;
      pc_out_q  <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      next_pc_q <= next_pc_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model answers requests, directed scenarios
// push expected fetches/deliveries, and a monitor pops and compares them.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_target;
  logic        halted;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  int mem_cnt = 0;
  logic slow6 = 1'b0;

  logic [31:0] mem [256];
  logic [39:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];

  fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'h00), .HALT_OP(6'd63)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target), .halted(halted),
    .dbg_state_o(dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [7:0] a);
    logic [5:0] o;
    o = (a[5:0] == 6'd63) ? 6'd0 : a[5:0];
    return {o, 18'h0, a};
  endfunction

  function automatic int wait_for(input logic [7:0] a);
    return (slow6 && a == 8'd6) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_x(input logic [7:0] pc);
    exp_q.push_back({pc, mem[pc]});
  endtask

  // memory model: answers after wait_for() extra request cycles
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req) begin
        if (mem_cnt == wait_for(imem_addr)) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          mem_cnt    = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          mem_cnt++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt    = 0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [39:0] e;
    logic [7:0]  a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_ack && imem_req) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fetch_unexpected: addr %0h, nothing expected", imem_addr);
          end else begin
            a = exp_addr_q.pop_front();
            check("fetch_addr", 64'(imem_addr), 64'(a));
          end
        end
        if (instr_valid && instr_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_unexpected: pc %0h instr %0h, nothing expected", pc_out, instr);
          end else begin
            e = exp_q.pop_front();
            check("xfer_pc", 64'(pc_out), 64'(e[39:32]));
            check("xfer_instr", 64'(instr), 64'(e[31:0]));
            check("xfer_op", 64'(op), 64'(e[31:26]));
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    n_xfer      = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'h00);
      check("rst_pc_out", 64'(pc_out), 64'h00);
      check("rst_instr", 64'(instr), 64'h0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (n_xfer >= n) break;
    end
    check("wait_xfers", 64'(n_xfer), 64'(n));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    check("wait_valid", 64'(instr_valid), 64'd1);
  endtask

  task automatic end_test();
    check("xfer_q_empty", 64'(exp_q.size()), 64'd0);
    check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = word(8'(a));

    // reset, in-order start, then backpressure on pc 4
    do_reset();
    for (int k = 0; k < 5; k++) push_x(8'(k));
    for (int k = 0; k < 6; k++) exp_addr_q.push_back(8'(k));
    instr_ready = 1'b1;
    wait_xfers(4);
    instr_ready = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_valid", 64'(instr_valid), 64'd1);
      check("bp_pc", 64'(pc_out), 64'h04);
      check("bp_op", 64'(op), 64'd4);
      check("bp_instr", 64'(instr), 64'h1000_0004);
      check("bp_req", 64'(imem_req), 64'd0);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    @(negedge clk);
    check("bp_req_handshake", 64'(imem_req), 64'd0);
    @(negedge clk);
    check("bp_req_next", 64'(imem_req), 64'd1);
    check("bp_addr_next", 64'(imem_addr), 64'h05);
    @(posedge clk);
    #1;
    end_test();

    // redirect while pc 3 sits in the buffer
    do_reset();
    for (int k = 0; k < 3; k++) push_x(8'(k));
    push_x(8'h8A);
    for (int k = 0; k < 4; k++) exp_addr_q.push_back(8'(k));
    exp_addr_q.push_back(8'h8A);
    instr_ready = 1'b1;
    wait_xfers(3);
    instr_ready = 1'b0;
    wait_valid();
    check("hold_pc3", 64'(pc_out), 64'h03);
    @(posedge clk);
    #1;
    redirect        = 1'b1;
    redirect_target = 8'h8A;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("redir_valid", 64'(instr_valid), 64'd0);
    check("redir_req", 64'(imem_req), 64'd1);
    check("redir_addr", 64'(imem_addr), 64'h8A);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    wait_xfers(4);
    end_test();

    // redirect while a slow request to address 6 is outstanding
    do_reset();
    slow6 = 1'b1;
    for (int k = 0; k < 6; k++) push_x(8'(k));
    push_x(8'h20);
    for (int k = 0; k < 7; k++) exp_addr_q.push_back(8'(k));
    exp_addr_q.push_back(8'h20);
    instr_ready = 1'b1;
    wait_xfers(6);
    redirect        = 1'b1;
    redirect_target = 8'h20;
    @(negedge clk);
    check("wait_addr_c1", 64'(imem_addr), 64'h06);
    check("wait_req_c1", 64'(imem_req), 64'd1);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("wait_addr_c2", 64'(imem_addr), 64'h06);
    check("wait_req_c2", 64'(imem_req), 64'd1);
    @(negedge clk);
    check("wait_addr_c3", 64'(imem_addr), 64'h06);
    check("wait_ack_c3", 64'(imem_ack), 64'd1);
    @(negedge clk);
    check("flush_valid", 64'(instr_valid), 64'd0);
    check("flush_req", 64'(imem_req), 64'd1);
    check("flush_addr", 64'(imem_addr), 64'h20);
    wait_xfers(7);
    end_test();
    slow6 = 1'b0;

    // HALT at address 2, then restart by redirect
    do_reset();
    mem[2] = {6'd63, 18'h0, 8'h02};
    for (int k = 0; k < 3; k++) push_x(8'(k));
    push_x(8'h40);
    for (int k = 0; k < 3; k++) exp_addr_q.push_back(8'(k));
    exp_addr_q.push_back(8'h40);
    instr_ready = 1'b1;
    wait_xfers(3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_req", 64'(imem_req), 64'd0);
      check("halt_valid", 64'(instr_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    redirect        = 1'b1;
    redirect_target = 8'h40;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("unhalt_halted", 64'(halted), 64'd0);
    check("unhalt_req", 64'(imem_req), 64'd1);
    check("unhalt_addr", 64'(imem_addr), 64'h40);
    wait_xfers(4);
    end_test();
    mem[2] = word(8'h02);

    // redirect to 8'hFF with simultaneous transfer, wrap, async reset mid-HOLD
    do_reset();
    push_x(8'h00);
    exp_addr_q.push_back(8'h00);
    wait_valid();
    @(posedge clk);
    #1;
    redirect        = 1'b1;
    redirect_target = 8'hFF;
    instr_ready     = 1'b1;
    push_x(8'hFF);
    push_x(8'h00);
    exp_addr_q.push_back(8'hFF);
    exp_addr_q.push_back(8'h00);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    wait_xfers(3);
    instr_ready = 1'b0;
    exp_addr_q.push_back(8'h01);
    wait_valid();
    check("wrap_hold_pc", 64'(pc_out), 64'h01);
    check("wrap_xfer_q_empty", 64'(exp_q.size()), 64'd0);
    check("wrap_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(instr_valid), 64'd0);
    check("async_req", 64'(imem_req), 64'd0);
    check("async_addr", 64'(imem_addr), 64'h00);
    do_reset();
    push_x(8'h00);
    push_x(8'h01);
    exp_addr_q.push_back(8'h00);
    exp_addr_q.push_back(8'h01);
    instr_ready = 1'b1;
    wait_xfers(2);
    end_test();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
